// File: rtl/mac_accum_if.sv
// Beat and result handshake between a mac_block_N array consumer and its stage.
// The master drives beats and takes results; the slave is mac_accum_stage.
interface mac_accum_if #(
    parameter int INT_W = 32,
    parameter int ACC_W = 48
) ();
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] p0;
    logic [INT_W-1:0] p1;
    logic [INT_W-1:0] p2;
    logic [INT_W-1:0] p3;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    modport master (
        output in_valid, p0, p1, p2, p3, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  in_valid, p0, p1, p2, p3, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/mac_accum_stage.sv
// Recombines per-block partial products (SINGLE/DUAL/QUAD) and accumulates a
// window of beats onto an initial value. Pipeline: S1 combine, S2 accumulate.
//
// state | meaning
// IDLE  | no window open, waiting for start
// ACCUM | accepting beats and accumulating
// HOLD  | result presented on acc_out until out_ready
module mac_accum_stage #(
    parameter int MIN_W = 8,
    parameter int INT_W = 32,
    parameter int ACC_W = 48,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] init_value,
    output logic             busy,
    mac_accum_if.slave       bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   init_q, init_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]   s1_prod_q, s1_prod_d;
    logic               s1_last_q, s1_last_d;

    logic [ACC_W-1:0]   prod;
    logic [ACC_W:0]     sum;
    logic               in_ready_c;

    always_comb begin
        prod = '0;
        case (mode_q)
            MODE_SINGLE: prod = ACC_W'(bus.p0);
            MODE_DUAL:   prod = ACC_W'(bus.p0) + (ACC_W'(bus.p1) << MIN_W);
            MODE_QUAD:   prod = ACC_W'(bus.p0) + (ACC_W'(bus.p1) << MIN_W)
                              + (ACC_W'(bus.p2) << (2 * MIN_W))
                              + (ACC_W'(bus.p3) << (3 * MIN_W));
            default:     prod = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        init_d      = init_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        s1_valid_d  = 1'b0;
        s1_prod_d   = s1_prod_q;
        s1_last_d   = s1_last_q;
        in_ready_c  = 1'b0;
        sum         = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = (len == '0) ? LEN_W'(1) : len;
                    init_d  = init_value;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    first_d = 1'b1;
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // S2 drains S1 every cycle, so only the beat budget gates input.
                in_ready_c = (cnt_q < len_q);
                if (bus.in_valid && in_ready_c) begin
                    s1_valid_d = 1'b1;
                    s1_prod_d  = prod;
                    s1_last_d  = (cnt_q == len_q - LEN_W'(1));
                    cnt_d      = cnt_q + LEN_W'(1);
                end
                if (s1_valid_q) begin
                    sum     = {1'b0, (first_q ? init_q : acc_q)} + {1'b0, s1_prod_q};
                    acc_d   = sum[ACC_W-1:0];
                    first_d = 1'b0;
                    if (sum[ACC_W]) ovf_d = 1'b1;
                    if (s1_last_q) begin
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            len_q       <= '0;
            init_q      <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            init_q      <= init_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_last_q   <= s1_last_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage with hand-computed window results.
module tb_mac_accum_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  len = 8'd0;
    logic [47:0] init_value = '0;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    mac_accum_if #(.INT_W(32), .ACC_W(48)) bus ();

    mac_accum_stage dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .init_value (init_value),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Config is scrambled right after start to show it was latched.
    task automatic do_start(input logic [1:0] m, input logic [7:0] l, input logic [47:0] iv);
        start = 1'b1; mode = m; len = l; init_value = iv;
        step();
        start = 1'b0; mode = 2'b11; len = 8'd9; init_value = 48'hABCDEF;
    endtask

    task automatic feed(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        int n = 0;
        bus.p0 = a; bus.p1 = b; bus.p2 = c; bus.p3 = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(bus.in_ready), 64'd1);
        step();
    endtask

    task automatic wait_result(input string tag, input logic [47:0] exp_acc, input logic exp_ovf);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ovalid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_acc"}, 64'(bus.acc_out), 64'(exp_acc));
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
        step();
        chk({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic feed_t1(input string tag);
        do_start(2'b10, 8'd3, 48'd10);
        for (int i = 0; i < 3; i++) feed(tag, 32'd1, 32'd1, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.p0 = '0; bus.p1 = '0; bus.p2 = '0; bus.p3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_acc", 64'(bus.acc_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // T1: 10 + 3*257, result two cycles after the last accept
        feed_t1("t1_feed");
        chk("t1_lat0", 64'(bus.out_valid), 64'd0);
        chk("t1_no_more_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("t1_lat1", 64'(bus.out_valid), 64'd1);
        wait_result("t1", 48'd781, 1'b0);

        // T2: 0xFF + 2*256, gap, then +1
        do_start(2'b01, 8'd2, 48'd0);
        feed("t2_feed0", 32'hFF, 32'd2, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        repeat (3) step();
        feed("t2_feed1", 32'd1, 32'd0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        wait_result("t2", 48'd768, 1'b0);

        // T3: wrap sets overflow, next window clears it
        do_start(2'b00, 8'd1, 48'hFFFF_FFFF_FFFF);
        feed("t3_feed", 32'd1, 32'd0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        wait_result("t3_wrap", 48'd0, 1'b1);
        do_start(2'b00, 8'd1, 48'd5);
        feed("t3b_feed", 32'd1, 32'd0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        wait_result("t3_next", 48'd6, 1'b0);

        // T4: backpressure with ignored start pulses in HOLD
        bus.out_ready = 1'b0;
        feed_t1("t4_feed");
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t4_hold_acc", 64'(bus.acc_out), 64'd781);
            chk("t4_hold_ready", 64'(bus.in_ready), 64'd0);
            start = (i % 2 == 0); mode = 2'b00; len = 8'd1; init_value = 48'd0;
            step();
        end
        start = 1'b0;
        chk("t4_still_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_still_acc", 64'(bus.acc_out), 64'd781);
        bus.out_ready = 1'b1;
        step();
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_ovalid_drop", 64'(bus.out_valid), 64'd0);
        step();
        chk("t4_stay_idle", 64'(busy), 64'd0);

        // T5: len=0 means one beat; reserved mode adds nothing
        do_start(2'b00, 8'd0, 48'd0);
        feed("t5_feed", 32'd7, 32'd0, 32'd0, 32'd0);
        chk("t5_one_beat", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_result("t5_len0", 48'd7, 1'b0);
        do_start(2'b11, 8'd2, 48'd123);
        feed("t5r_feed0", 32'd9, 32'd9, 32'd9, 32'd9);
        feed("t5r_feed1", 32'd9, 32'd9, 32'd9, 32'd9);
        bus.in_valid = 1'b0;
        wait_result("t5_rsvd", 48'd123, 1'b0);

        // T6: reset mid-window clears everything immediately
        do_start(2'b10, 8'd3, 48'd10);
        feed("t6_feed", 32'd1, 32'd1, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk("t6_partial", 64'(bus.acc_out), 64'd267);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_acc", 64'(bus.acc_out), 64'd0);
        chk("t6_rst_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_rst_ovalid", 64'(bus.out_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
        feed_t1("t6_t1_feed");
        wait_result("t6_t1", 48'd781, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
